// File: rtl/serial_loader_pkg.sv
// Shared constants for the serial program loader: sync byte, error codes,
// loader FSM encoding and instruction-RAM address width.
// No logic, no latency, no backpressure.
package serial_loader_pkg;

   localparam int ADDR_W = 11;

   localparam logic [7:0] SYNC_BYTE = 8'hA5;

   typedef enum logic [1:0] {
      ERR_NONE    = 2'd0,
      ERR_FRAMING = 2'd1,
      ERR_COUNT   = 2'd2,
      ERR_TIMEOUT = 2'd3    // also reported for a checksum mismatch
   } err_code_e;

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_CNT_LO = 3'd1;
   localparam logic [2:0] ST_CNT_HI = 3'd2;
   localparam logic [2:0] ST_DATA   = 3'd3;
   localparam logic [2:0] ST_CSUM   = 3'd4;
   localparam logic [2:0] ST_FINISH = 3'd5;

endpackage

// File: rtl/serial_rx_byte.sv
// 8N1 byte receiver: 2-flop synchronizer, mid-bit sampling, glitch-rejecting start detect.
// Latency: byte_valid/byte_err pulse 9.5*DIV+3 clk after the start edge on rx.
// Backpressure: none; every byte is presented for exactly one cycle.
// Ports: clk, rst (async, active-high), rx (idle high, async),
//        byte_valid/byte_data (good byte), byte_err (stop bit sampled low).
module serial_rx_byte #(
   parameter int DIV = 53333
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rx,
   output logic       byte_valid,
   output logic [7:0] byte_data,
   output logic       byte_err
);

   localparam int CW = $clog2(DIV);
   localparam logic [CW-1:0] HALF_M1 = CW'(DIV / 2 - 1);
   localparam logic [CW-1:0] FULL_M1 = CW'(DIV - 1);

   logic          rx_s1, rx_s2, rx_prev;
   logic          active;
   logic [CW-1:0] cnt;
   logic [3:0]    bitn;     // 0 = start, 1..8 = data, 9 = stop
   logic [7:0]    shreg;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rx_s1      <= 1'b1;
         rx_s2      <= 1'b1;
         rx_prev    <= 1'b1;
         active     <= 1'b0;
         cnt        <= '0;
         bitn       <= '0;
         shreg      <= '0;
         byte_valid <= 1'b0;
         byte_data  <= '0;
         byte_err   <= 1'b0;
      end else begin
         rx_s1      <= rx;
         rx_s2      <= rx_s1;
         rx_prev    <= rx_s2;
         byte_valid <= 1'b0;
         byte_err   <= 1'b0;
         if (!active) begin
            // falling edge: first sample lands half a bit later, mid start bit
            if (!rx_s2 && rx_prev) begin
               active <= 1'b1;
               cnt    <= HALF_M1;
               bitn   <= '0;
            end
         end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
         end else begin
            cnt  <= FULL_M1;
            bitn <= bitn + 4'd1;
            if (bitn == 4'd0) begin
               if (rx_s2)
                  active <= 1'b0;   // start bit gone high again: glitch
            end else if (bitn <= 4'd8) begin
               shreg <= {rx_s2, shreg[7:1]};
            end else begin
               // released mid stop bit; the line is high so no false edge follows
               active <= 1'b0;
               if (rx_s2) begin
                  byte_valid <= 1'b1;
                  byte_data  <= shreg;
               end else begin
                  byte_err <= 1'b1;
               end
            end
         end
      end
   end

endmodule

// File: rtl/serial_loader.sv
// Serial program loader: 0xA5, 16-bit LE word count, LE data words -> instruction RAM from 0.
// Latency: RAM_WEN 1 clk after the lane-3 byte; DONE 1 clk after last write / checksum byte.
// Backpressure: none; the RAM accepts one write per cycle.
// Ports: CLK, RST (async, active-high), RX; RAM_WADDR/RAM_WDATA/RAM_WEN write port;
//        BUSY (frame in progress), DONE (pulse), ERR (sticky), ERR_CODE.
// Option: define SERIAL_LOADER_CHECKSUM_EN to require a trailing mod-256 sum byte.
module serial_loader
   import serial_loader_pkg::*;
#(
   parameter int          DIV     = 53333,
   parameter logic [31:0] TIMEOUT = 32'd16000000,
   parameter int          DEPTH   = 2048
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              RX,
   output logic [ADDR_W-1:0] RAM_WADDR,
   output logic [31:0]       RAM_WDATA,
   output logic              RAM_WEN,
   output logic              BUSY,
   output logic              DONE,
   output logic              ERR,
   output logic [1:0]        ERR_CODE
);

   localparam logic [16:0] DEPTH_L = 17'(DEPTH);
   localparam logic [31:0] TO_M1   = TIMEOUT - 32'd1;
`ifdef SERIAL_LOADER_CHECKSUM_EN
   localparam logic [2:0]  ST_AFTER_DATA = ST_CSUM;
`else
   localparam logic [2:0]  ST_AFTER_DATA = ST_FINISH;
`endif

   logic       byte_valid, byte_err;
   logic [7:0] byte_data;

   serial_rx_byte #(.DIV(DIV)) u_rx (
      .clk        (CLK),
      .rst        (RST),
      .rx         (RX),
      .byte_valid (byte_valid),
      .byte_data  (byte_data),
      .byte_err   (byte_err)
   );

   logic [2:0]        state;
   logic [7:0]        cnt_lo;
   logic [ADDR_W:0]   last_idx;   // N-1, one bit wider so N = DEPTH fits
   logic [ADDR_W-1:0] widx;
   logic [1:0]        lane;
   logic [23:0]       word_sh;    // lanes 0..2 of the word being assembled
   logic [31:0]       timer;
`ifdef SERIAL_LOADER_CHECKSUM_EN
   logic [7:0]        csum;
`endif

   logic [15:0] n_words;
   logic        in_frame, timeout;

   assign n_words  = {byte_data, cnt_lo};
   assign in_frame = (state != ST_IDLE) && (state != ST_FINISH);
   assign timeout  = in_frame && !byte_valid && (timer == TO_M1);

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state     <= ST_IDLE;
         cnt_lo    <= '0;
         last_idx  <= '0;
         widx      <= '0;
         lane      <= '0;
         word_sh   <= '0;
         timer     <= '0;
`ifdef SERIAL_LOADER_CHECKSUM_EN
         csum      <= '0;
`endif
         RAM_WADDR <= '0;
         RAM_WDATA <= '0;
         RAM_WEN   <= 1'b0;
         BUSY      <= 1'b0;
         DONE      <= 1'b0;
         ERR       <= 1'b0;
         ERR_CODE  <= ERR_NONE;
      end else begin
         RAM_WEN <= 1'b0;
         DONE    <= 1'b0;

         if (in_frame && !byte_valid)
            timer <= timer + 32'd1;
         else
            timer <= '0;

         if (in_frame && byte_err) begin
            state    <= ST_IDLE;
            BUSY     <= 1'b0;
            ERR      <= 1'b1;
            ERR_CODE <= ERR_FRAMING;
         end else if (timeout) begin
            state    <= ST_IDLE;
            BUSY     <= 1'b0;
            ERR      <= 1'b1;
            ERR_CODE <= ERR_TIMEOUT;
         end else begin
            case (state)
               ST_IDLE: begin
                  if (byte_valid && byte_data == SYNC_BYTE) begin
                     state    <= ST_CNT_LO;
                     BUSY     <= 1'b1;
                     ERR      <= 1'b0;
                     ERR_CODE <= ERR_NONE;
                     widx     <= '0;
                     lane     <= '0;
`ifdef SERIAL_LOADER_CHECKSUM_EN
                     csum     <= '0;
`endif
                  end
               end
               ST_CNT_LO: begin
                  if (byte_valid) begin
                     cnt_lo <= byte_data;
                     state  <= ST_CNT_HI;
                  end
               end
               ST_CNT_HI: begin
                  if (byte_valid) begin
                     if ({1'b0, n_words} > DEPTH_L) begin
                        state    <= ST_IDLE;
                        BUSY     <= 1'b0;
                        ERR      <= 1'b1;
                        ERR_CODE <= ERR_COUNT;
                     end else if (n_words == 16'd0) begin
                        state <= ST_AFTER_DATA;
                     end else begin
                        last_idx <= 12'(n_words - 16'd1);
                        state    <= ST_DATA;
                     end
                  end
               end
               ST_DATA: begin
                  if (byte_valid) begin
`ifdef SERIAL_LOADER_CHECKSUM_EN
                     csum <= csum + byte_data;
`endif
                     lane <= lane + 2'd1;
                     if (lane == 2'd3) begin
                        RAM_WEN   <= 1'b1;
                        RAM_WADDR <= widx;
                        RAM_WDATA <= {byte_data, word_sh};
                        // wraps to 0 after a full-depth load, but is never used again
                        widx      <= widx + 1'b1;
                        if ({1'b0, widx} == last_idx)
                           state <= ST_AFTER_DATA;
                     end else begin
                        word_sh <= {byte_data, word_sh[23:8]};
                     end
                  end
               end
`ifdef SERIAL_LOADER_CHECKSUM_EN
               ST_CSUM: begin
                  if (byte_valid) begin
                     state <= ST_IDLE;
                     BUSY  <= 1'b0;
                     if (byte_data == csum) begin
                        DONE <= 1'b1;
                     end else begin
                        ERR      <= 1'b1;
                        ERR_CODE <= ERR_TIMEOUT;
                     end
                  end
               end
`endif
               ST_FINISH: begin
                  DONE  <= 1'b1;
                  BUSY  <= 1'b0;
                  state <= ST_IDLE;
               end
               default: state <= ST_IDLE;
            endcase
         end
      end
   end

endmodule
